// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS core.
//
// This block consumes the instruction that the IFU fetched and that is
// now held in the IR. It steers the IFU next-PC controls and drives the
// register-file, extender, ALU and data-memory strobes. It also keeps a
// retired-instruction counter and a sticky illegal-instruction flag.
//
// Ports:
//   clk      in   system clock, all state updates on the rising edge
//   reset    in   asynchronous active-high reset
//   inst     in   [31:0] current instruction held in the IR
//   zero     in   ALU result == 0, valid while in EXEC
//   ir_we    out  load the IR from the IFU
//   pc_we    out  IFU PC update enable
//   npc_sel  out  [1:0] 00 PC+4, 01 branch-relative, 10 jump target, 11 GPR[rs]
//   reg_we   out  GPR write enable
//   reg_dst  out  [1:0] 0 rt, 1 rd, 2 $31
//   wd_sel   out  [1:0] 0 ALU, 1 DM, 2 PC+4
//   alu_src  out  0 GPR[rt], 1 extended immediate
//   ext_op   out  [1:0] 0 zero-extend, 1 sign-extend, 2 imm16<<16
//   alu_op   out  [1:0] 0 add, 1 sub, 2 or
//   mem_we   out  DM write enable
//   illegal  out  sticky undefined-instruction flag
//   retired  out  [CNT_W-1:0] number of completed instructions
//   state    out  [2:0] current FSM state, for debug
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst,
  input  logic             zero,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [1:0]       ext_op,
  output logic [1:0]       alu_op,
  output logic             mem_we,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [1:0] NPC_NORM  = 2'b00;
  localparam logic [1:0] NPC_REL   = 2'b01;
  localparam logic [1:0] NPC_IRREL = 2'b10;
  localparam logic [1:0] NPC_REG   = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;

  state_t           state_q;
  state_t           state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic isNop, isRtype, isAddu, isSubu, isJr;
  logic isOri, isLui, isLw, isSw, isBeq, isJ, isJal;
  logic isLegal;

  logic       irWe, pcWe, regWe, memWe, aluSrc;
  logic [1:0] npcSel, regDst, wdSel, extOp, aluOp;
  logic       skipIllegal;

  logic       aluSrcInst;
  logic [1:0] extOpInst, aluOpInst;

  // Instruction decode from the held IR. The all-zero word is a nop and
  // must not be taken as an R-type with funct 0.
  always_comb begin
    opcode  = inst[31:26];
    funct   = inst[5:0];
    isNop   = (inst == 32'h0000_0000);
    isRtype = (opcode == 6'h00) && !isNop;
    isAddu  = isRtype && (funct == 6'h21);
    isSubu  = isRtype && (funct == 6'h23);
    isJr    = isRtype && (funct == 6'h08);
    isOri   = (opcode == 6'h0d);
    isLui   = (opcode == 6'h0f);
    isLw    = (opcode == 6'h23);
    isSw    = (opcode == 6'h2b);
    isBeq   = (opcode == 6'h04);
    isJ     = (opcode == 6'h02);
    isJal   = (opcode == 6'h03);
    isLegal = isNop | isAddu | isSubu | isJr | isOri | isLui |
              isLw | isSw | isBeq | isJ | isJal;
  end

  // ALU/extender controls for the current instruction. These are applied
  // in EXEC and held unchanged through MEM and WB so the datapath result
  // stays stable until it is consumed.
  always_comb begin
    aluSrcInst = 1'b0;
    extOpInst  = EXT_ZERO;
    aluOpInst  = ALU_ADD;
    if (isBeq || isSubu) begin
      aluOpInst = ALU_SUB;
    end else if (isOri) begin
      aluSrcInst = 1'b1;
      extOpInst  = EXT_ZERO;
      aluOpInst  = ALU_OR;
    end else if (isLui) begin
      aluSrcInst = 1'b1;
      extOpInst  = EXT_LUI;
      aluOpInst  = ALU_OR;
    end else if (isLw || isSw) begin
      aluSrcInst = 1'b1;
      extOpInst  = EXT_SIGN;
      aluOpInst  = ALU_ADD;
    end
  end

  // Next-state and raw (ungated) output decode. Every select defaults to
  // zero so it only carries a value in the states that actually use it.
  always_comb begin
    state_d     = FETCH;
    irWe        = 1'b0;
    pcWe        = 1'b0;
    npcSel      = NPC_NORM;
    regWe       = 1'b0;
    regDst      = 2'd0;
    wdSel       = 2'd0;
    aluSrc      = 1'b0;
    extOp       = EXT_ZERO;
    aluOp       = ALU_ADD;
    memWe       = 1'b0;
    skipIllegal = 1'b0;

    case (state_q)
      FETCH: begin
        irWe    = 1'b1;
        state_d = DECODE;
      end

      DECODE: begin
        if (isJ) begin
          pcWe   = 1'b1;
          npcSel = NPC_IRREL;
        end else if (isJal) begin
          // Link value is the old PC+4, written on the same edge the PC moves.
          pcWe   = 1'b1;
          npcSel = NPC_IRREL;
          regWe  = 1'b1;
          regDst = 2'd2;
          wdSel  = 2'd2;
        end else if (isJr) begin
          pcWe   = 1'b1;
          npcSel = NPC_REG;
        end else if (isNop) begin
          pcWe   = 1'b1;
          npcSel = NPC_NORM;
        end else if (!isLegal) begin
          // Undefined encodings are skipped: PC advances but nothing retires.
          pcWe        = 1'b1;
          npcSel      = NPC_NORM;
          skipIllegal = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (isBeq) begin
          aluSrc  = aluSrcInst;
          extOp   = extOpInst;
          aluOp   = aluOpInst;
          pcWe    = 1'b1;
          npcSel  = zero ? NPC_REL : NPC_NORM;
          state_d = FETCH;
        end else if (isAddu || isSubu || isOri || isLui) begin
          aluSrc  = aluSrcInst;
          extOp   = extOpInst;
          aluOp   = aluOpInst;
          state_d = WB;
        end else if (isLw || isSw) begin
          aluSrc  = aluSrcInst;
          extOp   = extOpInst;
          aluOp   = aluOpInst;
          state_d = MEM;
        end else begin
          state_d = FETCH;
        end
      end

      MEM: begin
        aluSrc = aluSrcInst;
        extOp  = extOpInst;
        aluOp  = aluOpInst;
        if (isSw) begin
          memWe   = 1'b1;
          pcWe    = 1'b1;
          npcSel  = NPC_NORM;
          state_d = FETCH;
        end else if (isLw) begin
          state_d = WB;
        end else begin
          state_d = FETCH;
        end
      end

      WB: begin
        aluSrc  = aluSrcInst;
        extOp   = extOpInst;
        aluOp   = aluOpInst;
        regWe   = 1'b1;
        pcWe    = 1'b1;
        npcSel  = NPC_NORM;
        regDst  = isRtype ? 2'd1 : 2'd0;
        wdSel   = isLw ? 2'd1 : 2'd0;
        state_d = FETCH;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Architectural state: FSM register, sticky illegal flag and the
  // retired counter, which counts every PC update except illegal skips.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (skipIllegal) begin
        illegal_q <= 1'b1;
      end
      if (pcWe && !skipIllegal) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // Reset forces every strobe and select low so an aborted instruction
  // cannot write anything, even though FETCH would otherwise assert ir_we.
  assign ir_we   = irWe  & ~reset;
  assign pc_we   = pcWe  & ~reset;
  assign reg_we  = regWe & ~reset;
  assign mem_we  = memWe & ~reset;
  assign alu_src = aluSrc & ~reset;
  assign npc_sel = reset ? 2'd0 : npcSel;
  assign reg_dst = reset ? 2'd0 : regDst;
  assign wd_sel  = reset ? 2'd0 : wdSel;
  assign ext_op  = reset ? 2'd0 : extOp;
  assign alu_op  = reset ? 2'd0 : aluOp;

  assign illegal = illegal_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed testbench for mc_ctrl.
//
// Drives a linear sequence of instructions and checks the state
// sequence, strobes, selects, retired counter and illegal flag against
// hand-computed values at points 1 time unit after each rising edge.
module tb_mc_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] inst;
  logic        zero;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  npc_sel;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        alu_src;
  logic [1:0]  ext_op;
  logic [1:0]  alu_op;
  logic        mem_we;
  logic        illegal;
  logic [31:0] retired;
  logic [2:0]  state;

  int testsRun;
  int testsFailed;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .inst    (inst),
    .zero    (zero),
    .ir_we   (ir_we),
    .pc_we   (pc_we),
    .npc_sel (npc_sel),
    .reg_we  (reg_we),
    .reg_dst (reg_dst),
    .wd_sel  (wd_sel),
    .alu_src (alu_src),
    .ext_op  (ext_op),
    .alu_op  (alu_op),
    .mem_we  (mem_we),
    .illegal (illegal),
    .retired (retired),
    .state   (state)
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present the IR contents and ALU zero flag.
  task automatic applyStimulus(input logic [31:0] instVal, input logic zeroVal);
    inst = instVal;
    zero = zeroVal;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    applyStimulus(32'h0000_0000, 1'b0);

    // Power-on reset.
    stepClock();
    stepClock();
    checkOutput("por_state", 32'(state), 32'd0);
    checkOutput("por_ir_we", 32'(ir_we), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("por_release_ir_we", 32'(ir_we), 32'd1);

    // Reset pulse while an addu sits in EXEC.
    applyStimulus(32'h0022_1821, 1'b0);
    stepClock();
    stepClock();
    checkOutput("abort_pre_state", 32'(state), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("abort_state", 32'(state), 32'd0);
    checkOutput("abort_enables", {28'd0, ir_we, pc_we, reg_we, mem_we}, 32'd0);
    checkOutput("abort_selects", {22'd0, npc_sel, reg_dst, wd_sel, ext_op, alu_op}, 32'd0);
    stepClock();
    checkOutput("abort_hold_enables", {28'd0, ir_we, pc_we, reg_we, mem_we}, 32'd0);
    checkOutput("abort_retired", retired, 32'd0);
    checkOutput("abort_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("abort_release_ir_we", 32'(ir_we), 32'd1);

    // addu $3,$1,$2: 0,1,2,4,0.
    checkOutput("addu_fetch_state", 32'(state), 32'd0);
    stepClock();
    checkOutput("addu_decode_state", 32'(state), 32'd1);
    checkOutput("addu_decode_pc_we", 32'(pc_we), 32'd0);
    stepClock();
    checkOutput("addu_exec_state", 32'(state), 32'd2);
    checkOutput("addu_exec_alu", {30'd0, alu_src, alu_op[0]}, 32'd0);
    stepClock();
    checkOutput("addu_wb_state", 32'(state), 32'd4);
    checkOutput("addu_wb_we", {29'd0, reg_we, pc_we, mem_we}, 32'b110);
    checkOutput("addu_wb_reg_dst", 32'(reg_dst), 32'd1);
    checkOutput("addu_wb_wd_sel", 32'(wd_sel), 32'd0);
    checkOutput("addu_wb_npc_sel", 32'(npc_sel), 32'd0);
    checkOutput("addu_wb_retired", retired, 32'd0);
    stepClock();
    checkOutput("addu_done_state", 32'(state), 32'd0);
    checkOutput("addu_done_retired", retired, 32'd1);

    // lw $2,4($1): 0,1,2,3,4.
    applyStimulus(32'h8C22_0004, 1'b0);
    stepClock();
    stepClock();
    checkOutput("lw_exec_state", 32'(state), 32'd2);
    checkOutput("lw_exec_ext_src", {29'd0, ext_op, alu_src}, 32'b011);
    stepClock();
    checkOutput("lw_mem_state", 32'(state), 32'd3);
    checkOutput("lw_mem_ext_src", {29'd0, ext_op, alu_src}, 32'b011);
    checkOutput("lw_mem_we", {30'd0, mem_we, pc_we}, 32'd0);
    stepClock();
    checkOutput("lw_wb_state", 32'(state), 32'd4);
    checkOutput("lw_wb_ext_src", {29'd0, ext_op, alu_src}, 32'b011);
    checkOutput("lw_wb_reg_dst", 32'(reg_dst), 32'd0);
    checkOutput("lw_wb_wd_sel", 32'(wd_sel), 32'd1);
    checkOutput("lw_wb_mem_we", 32'(mem_we), 32'd0);
    stepClock();
    checkOutput("lw_done_retired", retired, 32'd2);

    // beq taken.
    applyStimulus(32'h1022_FFFF, 1'b1);
    stepClock();
    stepClock();
    checkOutput("beq_t_exec_state", 32'(state), 32'd2);
    checkOutput("beq_t_pc_we", 32'(pc_we), 32'd1);
    checkOutput("beq_t_npc_sel", 32'(npc_sel), 32'd1);
    checkOutput("beq_t_alu_op", 32'(alu_op), 32'd1);
    stepClock();
    checkOutput("beq_t_done_state", 32'(state), 32'd0);
    checkOutput("beq_t_retired", retired, 32'd3);

    // beq not taken.
    applyStimulus(32'h1022_FFFF, 1'b0);
    stepClock();
    stepClock();
    checkOutput("beq_nt_pc_we", 32'(pc_we), 32'd1);
    checkOutput("beq_nt_npc_sel", 32'(npc_sel), 32'd0);
    stepClock();
    checkOutput("beq_nt_retired", retired, 32'd4);

    // jal then jr $31.
    applyStimulus(32'h0C00_0C00, 1'b0);
    stepClock();
    checkOutput("jal_decode_state", 32'(state), 32'd1);
    checkOutput("jal_we", {30'd0, pc_we, reg_we}, 32'b11);
    checkOutput("jal_npc_sel", 32'(npc_sel), 32'd2);
    checkOutput("jal_reg_dst", 32'(reg_dst), 32'd2);
    checkOutput("jal_wd_sel", 32'(wd_sel), 32'd2);
    stepClock();
    checkOutput("jal_done_state", 32'(state), 32'd0);
    applyStimulus(32'h03E0_0008, 1'b0);
    stepClock();
    checkOutput("jr_npc_sel", 32'(npc_sel), 32'd3);
    checkOutput("jr_we", {30'd0, pc_we, reg_we}, 32'b10);
    stepClock();
    checkOutput("jr_done_retired", retired, 32'd6);

    // sw $2,4($1): 0,1,2,3 then back to FETCH.
    applyStimulus(32'hAC22_0004, 1'b0);
    stepClock();
    stepClock();
    stepClock();
    checkOutput("sw_mem_state", 32'(state), 32'd3);
    checkOutput("sw_mem_we", {29'd0, mem_we, pc_we, reg_we}, 32'b110);
    checkOutput("sw_mem_ext_src", {29'd0, ext_op, alu_src}, 32'b011);
    stepClock();
    checkOutput("sw_done_state", 32'(state), 32'd0);
    checkOutput("sw_done_retired", retired, 32'd7);

    // lui: EXEC uses imm16<<16 with OR.
    applyStimulus(32'h3C01_1234, 1'b0);
    stepClock();
    stepClock();
    checkOutput("lui_exec_ctl", {27'd0, ext_op, alu_op, alu_src}, {27'd0, 2'd2, 2'd2, 1'b1});
    stepClock();
    checkOutput("lui_wb_state", 32'(state), 32'd4);
    checkOutput("lui_wb_reg_dst", 32'(reg_dst), 32'd0);
    stepClock();
    checkOutput("lui_done_retired", retired, 32'd8);

    // Undefined opcode is skipped without retiring.
    applyStimulus(32'hFC00_0000, 1'b0);
    stepClock();
    checkOutput("ill_decode_pc_we", 32'(pc_we), 32'd1);
    checkOutput("ill_decode_npc_sel", 32'(npc_sel), 32'd0);
    stepClock();
    checkOutput("ill_done_state", 32'(state), 32'd0);
    checkOutput("ill_flag", 32'(illegal), 32'd1);
    checkOutput("ill_retired", retired, 32'd8);

    // nop after the illegal one: retires, flag stays set.
    applyStimulus(32'h0000_0000, 1'b0);
    stepClock();
    checkOutput("nop_decode_pc_we", 32'(pc_we), 32'd1);
    stepClock();
    checkOutput("nop_retired", retired, 32'd9);
    checkOutput("nop_flag_sticky", 32'(illegal), 32'd1);

    // Only reset clears the flag and counter.
    reset = 1'b1;
    #1;
    checkOutput("final_reset_illegal", 32'(illegal), 32'd0);
    checkOutput("final_reset_retired", retired, 32'd0);
    reset = 1'b0;
    stepClock();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
